muldiv_seq: RTL and testbench

- Multi-cycle sequencer for the integer multiply/divide path and owner of the architectural HI/LO registers.
- Accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from the execute stage.
- Runs a 32-iteration shift-add multiply or restoring divide, applies sign fix-up, then commits to HI/LO.
- Asserts busy so the pipeline stalls MFHI/MFLO and further mult/div issue while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_iter.sv | 30 +++
 rtl/muldiv_seq.sv | 193 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide sequencer.
package muldiv_pkg;

  localparam int MD_DATA_W = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } md_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// One shift-add multiply or restoring-divide step over the {upper, lower} accumulator.
module muldiv_iter #(
  parameter int W = 32
) (
  input  logic           is_div,
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   opnd,
  output logic [2*W-1:0] acc_nxt
);

  logic [W:0]   sum;
  logic [W:0]   sh_rem;
  logic [W-1:0] diff;
  logic         ge;

  always_comb begin
    // multiply: lower half holds the remaining multiplier bits, upper half the partial product
    sum    = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    // divide: upper half is the partial remainder, lower half shifts dividend out and quotient in
    sh_rem = acc[2*W-1:W-1];
    ge     = (sh_rem >= {1'b0, opnd});
    diff   = sh_rem[W-1:0] - opnd;
    if (is_div) begin
      acc_nxt = {(ge ? diff : sh_rem[W-1:0]), acc[W-2:0], ge};
    end else begin
      acc_nxt = {sum, acc[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/DIV sequencer and owner of the architectural HI/LO registers.
//
//   state | meaning
//   IDLE  | waiting for start; MTHI/MTLO write hi/lo directly
//   PREP  | take operand magnitudes, record signs and divide-by-zero
//   RUN   | DATA_W multiply/divide iterations, one per clock
//   FIX   | apply signs, commit hi/lo, pulse done
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int DATA_W = MD_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

  md_state_t          state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [DATA_W-1:0]  opnd_q, opnd_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic [DATA_W-1:0]  hi_q, hi_d;
  logic [DATA_W-1:0]  lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic                is_div;
  logic                is_signed;
  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;
  logic [2*DATA_W-1:0] acc_nxt;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

  assign is_div    = (op_q == MD_DIV) || (op_q == MD_DIVU);
  assign is_signed = (op_q == MD_MULT) || (op_q == MD_DIV);
  assign a_neg     = is_signed & a_q[DATA_W-1];
  assign b_neg     = is_signed & b_q[DATA_W-1];
  assign a_mag     = a_neg ? (~a_q + 1'b1) : a_q;
  assign b_mag     = b_neg ? (~b_q + 1'b1) : b_q;

  assign prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix  = neg_res_q ? (~acc_q[DATA_W-1:0] + 1'b1) : acc_q[DATA_W-1:0];
  assign rem_fix  = neg_rem_q ? (~acc_q[2*DATA_W-1:DATA_W] + 1'b1) : acc_q[2*DATA_W-1:DATA_W];

  muldiv_iter #(.W(DATA_W)) u_iter (
    .is_div  (is_div),
    .acc     (acc_q),
    .opnd    (opnd_q),
    .acc_nxt (acc_nxt)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          unique case (op)
            MD_MTHI: hi_d = op_a;
            MD_MTLO: lo_d = op_a;
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              op_d    = op;
              a_d     = op_a;
              b_d     = op_b;
              state_d = PREP;
            end
            default: ;
          endcase
        end
      end
      PREP: begin
        neg_res_d = a_neg ^ b_neg;
        neg_rem_d = a_neg;
        dz_d      = is_div && (b_q == '0);
        opnd_d    = is_div ? b_mag : a_mag;
        acc_d     = {{DATA_W{1'b0}}, (is_div ? a_mag : b_mag)};
        cnt_d     = '0;
        state_d   = RUN;
      end
      RUN: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        if (!is_div) begin
          {hi_d, lo_d} = prod_fix;
        end else if (dz_q) begin
          // divide-by-zero leaves the raw dividend in HI and all ones in LO
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d     = 1'b1;
        div_zero_d = dz_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // a flush cancels anything in flight with no commit
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      div_zero_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus random ops against a plain-arithmetic model.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        abort;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] ref_hi = '0;
  logic [31:0] ref_lo = '0;

  muldiv_seq #(.DATA_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .op_a     (op_a),
    .op_b     (op_b),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // architectural result of one op given the current HI/LO
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output logic ez);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    eh = ref_hi;
    el = ref_lo;
    ez = 1'b0;
    case (o)
      3'd0: begin p = longint'(sa * sb); eh = p[63:32]; el = p[31:0]; end
      3'd1: begin p = ua * ub;           eh = p[63:32]; el = p[31:0]; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          eh = a; el = 32'hFFFF_FFFF; ez = 1'b1;
        end else begin
          if (o == 3'd2) begin q = sa / sb; r = sa % sb; end
          else begin q = longint'(ua / ub); r = longint'(ua % ub); end
          eh = r[31:0];
          el = q[31:0];
        end
      end
      3'd4: eh = a;
      3'd5: el = a;
      default: ;
    endcase
  endtask

  // issue one op from idle (or the done cycle); hold keeps start high with an MTHI during busy
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit hold);
    logic [31:0] eh, el;
    logic        ez;
    int          n;
    model(o, a, b, eh, el, ez);
    op = o; op_a = a; op_b = b; start = 1'b1;
    tick();
    if (hold) begin
      op = 3'd4; op_a = 32'hDEAD_BEEF;
    end else begin
      start = 1'b0;
    end
    if (o >= 3'd4) begin
      check_val("mt_hi", {32'd0, hi}, {32'd0, eh});
      check_val("mt_lo", {32'd0, lo}, {32'd0, el});
      check_val("mt_busy_done", {62'd0, busy, done}, 64'd0);
    end else begin
      check_val("busy_after_accept", {63'd0, busy}, 64'd1);
      n = 0;
      while (!done && n < 60) begin
        check_val("hold_hilo", {hi, lo}, {ref_hi, ref_lo});
        tick();
        n++;
      end
      start = 1'b0;
      check_val("latency", 64'(n), 64'd34);
      check_val("busy_in_done", {63'd0, busy}, 64'd0);
      check_val("res_hi", {32'd0, hi}, {32'd0, eh});
      check_val("res_lo", {32'd0, lo}, {32'd0, el});
      check_val("div_zero", {63'd0, div_zero}, {63'd0, ez});
    end
    ref_hi = eh;
    ref_lo = el;
  endtask

  initial begin
    int n;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; op = '0; op_a = '0; op_b = '0;
    #3;
    check_val("reset_outs", {29'd0, busy, done, div_zero, hi}, 64'd0);
    check_val("reset_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op(3'd4, 32'h1234_5678, 32'd0, 1'b0);
    run_op(3'd5, 32'h9ABC_DEF0, 32'd0, 1'b0);

    // directed ops, chained back-to-back in each done cycle
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check_val("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check_val("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check_val("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd3, 32'd100, 32'd7, 1'b0);
    check_val("divu_b2b", {hi, lo}, {32'd2, 32'd14});
    run_op(3'd3, 32'd5, 32'd0, 1'b0);
    check_val("divu_zero", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check_val("div_ovf", {hi, lo}, {32'd0, 32'h8000_0000});
    tick();
    check_val("done_one_cycle", {62'd0, done, div_zero}, 64'd0);

    // reserved op codes leave no trace
    run_op(3'd6, 32'h5555_5555, 32'd1, 1'b0);
    run_op(3'd7, 32'hAAAA_AAAA, 32'd1, 1'b0);

    // abort together with start in idle: abort wins
    op = 3'd4; op_a = 32'hCAFE_0000; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_val("abort_idle_hi", {32'd0, hi}, {32'd0, ref_hi});

    // abort at RUN iteration 10
    op = 3'd0; op_a = 32'd1234; op_b = 32'd5678; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    check_val("busy_before_abort", {63'd0, busy}, 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("abort_busy", {63'd0, busy}, 64'd0);
    n = 0;
    repeat (40) begin
      if (done) n++;
      tick();
    end
    check_val("abort_no_done", 64'(n), 64'd0);
    check_val("abort_hilo", {hi, lo}, {ref_hi, ref_lo});

    // start held during busy must not re-trigger or act as MTHI
    run_op(3'd1, 32'd40000, 32'd70000, 1'b1);

    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      run_op(ro, ra, rb, 1'b0);
    end

    // asynchronous reset mid-RUN
    run_op(3'd1, 32'h0001_0001, 32'h0003_0003, 1'b0);
    op = 3'd2; op_a = 32'd999; op_b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_reset", {29'd0, busy, done, div_zero, hi}, 64'd0);
    check_val("async_reset_lo", {32'd0, lo}, 64'd0);
    ref_hi = '0;
    ref_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op(3'd3, 32'd1000, 32'd33, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
